lzc_stream: RTL and testbench

- Parametrised successor to the team's byte-serial leading-zero counter.
- Consumes a frame of WORD beats, each WIDTH bits wide and MSB-first, and reports the leading zero (or leading one) count of the concatenated frame.
- Adds valid/ready handshakes on input and output, an early-exit option, a leading-ones option and an all-zero flag.
- Sits between the operand streaming front end and the normalisation logic.

---
 rtl/lzc_pkg.sv | 18 +
 rtl/lzc_beat_enc.sv | 27 ++
 rtl/lzc_stream.sv | 109 ++++++++++
 tb/tb_lzc_stream.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared types and constants for the streaming leading-zero counter.
package lzc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCU,
      DONE
   } lzc_state_t;

   localparam int unsigned MODE_EARLY = 0;
   localparam int unsigned MODE_ONES  = 1;

   // Width needed to hold a count of 0..width*word inclusive.
   function automatic int unsigned lzc_zw(input int unsigned width, input int unsigned word);
      return $clog2(width * word + 1);
   endfunction

endpackage

// File: rtl/lzc_beat_enc.sv
// Combinational per-beat priority encoder: leading zeros of one beat.
module lzc_beat_enc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0]             operand,
   input  logic                         invert,
   output logic [$clog2(WIDTH+1)-1:0]   count,
   output logic                         nz
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] op;

   // Scan LSB upward so the highest set bit is the one that sticks.
   always_comb begin
      op    = invert ? ~operand : operand;
      nz    = |op;
      count = CW'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (op[i]) begin
            count = CW'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/lzc_stream.sv
// Streaming leading-zero/one counter over a frame of WORD beats, MSB-first.
module lzc_stream
   import lzc_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned WORD  = 16,
   parameter int unsigned ZW    = lzc_zw(WIDTH, WORD)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IVALID,
   output logic             IREADY,
   input  logic [WIDTH-1:0] DATA,
   input  logic [1:0]       MODE,
   output logic [ZW-1:0]    ZEROS,
   output logic             ALLZERO,
   output logic             OVALID,
   input  logic             OREADY
);

   localparam int unsigned CW   = $clog2(WIDTH + 1);
   localparam int unsigned CNTW = $clog2(WORD);

   lzc_state_t       state;
   logic [ZW-1:0]    acc;
   logic             found;
   logic [1:0]       mode_q;
   logic [CNTW-1:0]  cnt;

   logic [CW-1:0]    beat_cnt;
   logic             beat_nz;
   logic             accept;
   logic [1:0]       mode_eff;
   logic [ZW-1:0]    acc_next;
   logic             found_next;
   logic             terminate;

   assign IREADY = (state != DONE);
   assign accept = IVALID && IREADY;

   lzc_beat_enc #(
      .WIDTH(WIDTH)
   ) u_enc (
      .operand(DATA),
      .invert (mode_eff[MODE_ONES]),
      .count  (beat_cnt),
      .nz     (beat_nz)
   );

   // First beat of a frame sees live MODE and a cleared accumulator, so both
   // cases share one next-value path.
   always_comb begin
      logic [ZW-1:0] acc_base;
      logic          found_base;
      mode_eff   = (state == IDLE) ? MODE : mode_q;
      acc_base   = (state == IDLE) ? '0 : acc;
      found_base = (state == IDLE) ? 1'b0 : found;
      acc_next   = found_base ? acc_base : acc_base + ZW'(beat_cnt);
      found_next = found_base | beat_nz;
      terminate  = (mode_eff[MODE_EARLY] && beat_nz && !found_base) ||
                   ((state == ACCU) && (cnt == CNTW'(WORD - 1)));
   end

   // Frame FSM, accumulator, beat counter and registered result.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         acc     <= '0;
         found   <= 1'b0;
         mode_q  <= '0;
         cnt     <= '0;
         ZEROS   <= '0;
         ALLZERO <= 1'b0;
         OVALID  <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCU: begin
               if (accept) begin
                  if (state == IDLE) begin
                     mode_q <= MODE;
                  end
                  acc   <= acc_next;
                  found <= found_next;
                  if (terminate) begin
                     state   <= DONE;
                     cnt     <= '0;
                     ZEROS   <= acc_next;
                     ALLZERO <= ~found_next;
                     OVALID  <= 1'b1;
                  end else begin
                     state <= ACCU;
                     cnt   <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               if (OREADY) begin
                  state   <= IDLE;
                  ZEROS   <= '0;
                  ALLZERO <= 1'b0;
                  OVALID  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lzc_stream.sv
// Self-checking bench for lzc_stream with WIDTH=8, WORD=4.
module tb_lzc_stream;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned WORD  = 4;
   localparam int unsigned ZW    = 6;

   logic          CLK = 1'b0;
   logic          RST;
   logic          IVALID;
   logic          IREADY;
   logic [7:0]    DATA;
   logic [1:0]    MODE;
   logic [ZW-1:0] ZEROS;
   logic          ALLZERO;
   logic          OVALID;
   logic          OREADY;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   lzc_stream #(
      .WIDTH(WIDTH),
      .WORD (WORD)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .IVALID (IVALID),
      .IREADY (IREADY),
      .DATA   (DATA),
      .MODE   (MODE),
      .ZEROS  (ZEROS),
      .ALLZERO(ALLZERO),
      .OVALID (OVALID),
      .OREADY (OREADY)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: treat the frame as one 32-bit word, count leading target bits;
   // an early-exit frame is as long as the beat holding the first non-target bit.
   task automatic ref_model(input logic [1:0] mode, input logic [31:0] frame,
                            output int nbeats, output int zeros, output bit allz);
      bit stop;
      zeros = 0;
      stop  = 0;
      for (int i = 31; i >= 0; i--) begin
         if (!stop && frame[i] == mode[1]) zeros++;
         else stop = 1;
      end
      allz   = (zeros == 32);
      nbeats = (mode[0] && !allz) ? (zeros / 8 + 1) : 4;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic [1:0] m, input int gap);
      int waited;
      repeat (gap) begin
         @(negedge CLK);
         IVALID = 1'b0;
         DATA   = 8'($urandom);
      end
      @(negedge CLK);
      IVALID = 1'b1;
      DATA   = d;
      MODE   = m;
      waited = 0;
      while (!IREADY && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      if (!IREADY) check("iready_timeout", 0, 1);
      check("ovalid_low_in_frame", OVALID, 0);
      check("zeros_low_in_frame", ZEROS, 0);
      @(posedge CLK);
   endtask

   task automatic run_frame(input logic [1:0] mode, input logic [31:0] frame,
                            input int max_gap, input int hold);
      int  nb, ez, waited;
      bit  ea;
      logic [7:0] beat;
      ref_model(mode, frame, nb, ez, ea);
      for (int i = 0; i < nb; i++) begin
         beat = frame[31 - 8*i -: 8];
         send_beat(beat, (i == 0) ? mode : 2'($urandom), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      end
      @(negedge CLK);
      IVALID = 1'b0;
      check("ovalid_latency", OVALID, 1);
      waited = 0;
      while (!OVALID && waited < 20) begin
         @(negedge CLK);
         waited++;
      end
      check("zeros", ZEROS, ez);
      check("allzero", ALLZERO, ea);
      check("iready_done", IREADY, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge CLK);
         check("hold_ovalid", OVALID, 1);
         check("hold_zeros", ZEROS, ez);
         check("hold_allzero", ALLZERO, ea);
         check("hold_iready", IREADY, 0);
      end
      OREADY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      OREADY = 1'b0;
      check("ovalid_after_hs", OVALID, 0);
      check("zeros_after_hs", ZEROS, 0);
      check("allzero_after_hs", ALLZERO, 0);
      check("iready_after_hs", IREADY, 1);
   endtask

   function automatic logic [7:0] rand_beat();
      case ($urandom_range(0, 3))
         0:       return 8'h00;
         1:       return 8'hFF;
         2:       return 8'(1 << $urandom_range(0, 7));
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      logic [31:0] fr;
      RST    = 1'b1;
      IVALID = 1'b0;
      DATA   = '0;
      MODE   = '0;
      OREADY = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_ovalid", OVALID, 0);
      check("rst_zeros", ZEROS, 0);
      check("rst_allzero", ALLZERO, 0);
      check("rst_iready", IREADY, 1);
      RST = 1'b0;

      // Directed frames.
      run_frame(2'b00, 32'h00001FFF, 0, 0);   // 19
      run_frame(2'b01, 32'h00040000, 0, 0);   // early exit, 13
      run_frame(2'b00, 32'h80000000, 0, 0);   // 0, right after early exit
      run_frame(2'b10, 32'hFFF0A55A, 0, 0);   // leading ones, 12
      run_frame(2'b00, 32'h00000000, 0, 0);   // 32, allzero
      run_frame(2'b11, 32'hFFFFFFFF, 0, 0);   // ones, allzero, full frame
      run_frame(2'b00, 32'h00001FFF, 0, 5);   // back-pressure
      run_frame(2'b00, 32'h00001FFF, 4, 0);   // input gaps

      // Mid-frame reset discards the partial frame.
      send_beat(8'h00, 2'b00, 0);
      send_beat(8'h00, 2'b00, 0);
      @(negedge CLK);
      IVALID = 1'b0;
      RST    = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("midrst_ovalid", OVALID, 0);
      check("midrst_zeros", ZEROS, 0);
      RST = 1'b0;
      @(negedge CLK);
      check("postrst_ovalid", OVALID, 0);
      run_frame(2'b00, 32'h80000000, 0, 0);

      // Randomized frames.
      for (int f = 0; f < 60; f++) begin
         fr = {rand_beat(), rand_beat(), rand_beat(), rand_beat()};
         run_frame(2'($urandom), fr, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1);
   end

endmodule
